alu_share_arbiter: RTL

- Shares the single RV32I ALU between two requesters: req0 is the main execute stage, req1 is the branch/address-compare helper.
- Arbitrates round-robin, drives the ALU operand and control inputs, and registers the ALU result and zero flag into a per-requester response slot.
- Uses valid/ready handshakes on both the request and response sides.
- Has one-cycle request-to-response latency and full throughput of one ALU operation per cycle.

---
 rtl/alu_share_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one RV32I ALU between the execute stage (req0) and the branch/address helper (req1).
// Latency: request accepted in cycle T, registered result visible in cycle T+1; one ALU operation per cycle in total.
// Backpressure: a requester is granted only while its response slot is empty or draining in the same cycle.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid/ready           request handshake per requester (ready is the combinational grant)
//   reqN_op_a/op_b/ctrl        operands and ALU operation, sampled only in the grant cycle
//   rspN_valid/ready           response handshake per requester (single-entry slot)
//   rspN_result/zero           registered ALU result and zero flag
//   alu_op_a/op_b/ctrl         drive to the shared combinational ALU
//   alu_result/zero            combinational ALU outputs
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op_a,
    input  logic [DATA_W-1:0] req0_op_b,
    input  logic [CTRL_W-1:0] req0_ctrl,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op_a,
    input  logic [DATA_W-1:0] req1_op_b,
    input  logic [CTRL_W-1:0] req1_ctrl,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,

    output logic [DATA_W-1:0] alu_op_a,
    output logic [DATA_W-1:0] alu_op_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    // Idle ALU drive: ADD of zero operands keeps the ALU inputs quiet.
    localparam logic [CTRL_W-1:0] CTRL_ADD = '0;

    // prio = index of the requester that wins when both are eligible.
    logic prio;

    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;

    // Eligibility includes the "slot draining this cycle" case so that a
    // consumer taking its result lets the next op in without a bubble.
    // Everything is gated by rst_n so no handshake completes during reset.
    always_comb begin
        elig0  = 1'b0;
        elig1  = 1'b0;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
            elig1 = req1_valid && (!rsp1_valid || rsp1_ready);
            if (elig0 && elig1) begin
                grant0 = !prio;
                grant1 = prio;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // ALU operand mux; ctrl is forwarded untouched, including unused encodings.
    always_comb begin
        alu_op_a = '0;
        alu_op_b = '0;
        alu_ctrl = CTRL_ADD;
        if (grant0) begin
            alu_op_a = req0_op_a;
            alu_op_b = req0_op_b;
            alu_ctrl = req0_ctrl;
        end else if (grant1) begin
            alu_op_a = req1_op_a;
            alu_op_b = req1_op_b;
            alu_ctrl = req1_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio        <= 1'b0;
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
        end else begin
            // The loser of this cycle's grant gets priority next; with a
            // single grant the other side is favoured, which gives strict
            // alternation under contention.
            if (grant0 || grant1) begin
                prio <= grant0;
            end

            // A load wins over a same-cycle drain: the slot stays valid
            // with the fresh result (back-to-back, no bubble). A plain drain
            // only clears valid; the data is left as is.
            if (grant0) begin
                rsp0_valid  <= 1'b1;
                rsp0_result <= alu_result;
                rsp0_zero   <= alu_zero;
            end else if (rsp0_valid && rsp0_ready) begin
                rsp0_valid  <= 1'b0;
            end

            if (grant1) begin
                rsp1_valid  <= 1'b1;
                rsp1_result <= alu_result;
                rsp1_zero   <= alu_zero;
            end else if (rsp1_valid && rsp1_ready) begin
                rsp1_valid  <= 1'b0;
            end
        end
    end

endmodule
